// File: rtl/csr_unit.sv
// Machine-mode CSR block: trap/mret redirect, WFI wait state, cycle and retired-instruction counters.
// Optional feature: define CSR_INSTRET_EN to build the instret counter (0xB02/0xB82/0xC02/0xC82).
module csr_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        stall,
    input  logic        retire,
    input  logic        mret,
    input  logic        wfi,
    input  logic [31:0] irq_pc,
    input  logic        ext_irq,
    input  logic        tmr_irq,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        wfi_hold
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_r;
    logic        wfi_hold_r;
    logic        mstatus_mie_r;
    logic        mstatus_mpie_r;
    logic        mie_mtie_r;
    logic        mie_meie_r;
    logic [31:0] mtvec_r;
    logic [31:0] mepc_r;
    logic [63:0] cycle_r;
`ifdef CSR_INSTRET_EN
    logic [63:0] instret_r;
`endif

    logic [31:0] mstatus_s;
    logic [31:0] mie_s;
    logic [31:0] mip_s;
    logic [31:0] pending_s;
    logic [31:0] rd_val_s;
    logic [31:0] wval_s;
    logic        trap_s;
    logic        mret_s;
    logic        wfi_go_s;
    logic        csr_we_s;
    logic        unused_s;

    function automatic logic [31:0] csr_wval(input logic [1:0] op, input logic [31:0] old,
                                             input logic [31:0] wdata);
        case (op)
            2'b01:   csr_wval = wdata;
            2'b10:   csr_wval = old | wdata;
            2'b11:   csr_wval = old & ~wdata;
            default: csr_wval = old;
        endcase
    endfunction

    // Architectural views of the status/interrupt registers and the event qualifiers.
    always_comb begin
        mstatus_s     = 32'h0000_0000;
        mstatus_s[3]  = mstatus_mie_r;
        mstatus_s[7]  = mstatus_mpie_r;
        mie_s         = 32'h0000_0000;
        mie_s[7]      = mie_mtie_r;
        mie_s[11]     = mie_meie_r;
        mip_s         = 32'h0000_0000;
        mip_s[7]      = tmr_irq;
        mip_s[11]     = ext_irq;
        pending_s     = mip_s & mie_s;
        // Trap entry is only considered in RUN, so the WAIT->RUN wake cycle never traps.
        trap_s   = !rst && (state_r == ST_RUN) && mstatus_mie_r && (pending_s != 32'h0000_0000) && !stall;
        mret_s   = !rst && mret && !stall && !trap_s;
        wfi_go_s = (state_r == ST_RUN) && wfi && !stall && !trap_s;
        csr_we_s = csr_en && (csr_op != 2'b00) && !stall && !trap_s;
        wval_s   = csr_wval(csr_op, rd_val_s, csr_wdata);
    end

    // Read mux: current value of the addressed CSR, zero when unimplemented.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (csr_addr)
            A_MSTATUS:              rd_val_s = mstatus_s;
            A_MIE:                  rd_val_s = mie_s;
            A_MTVEC:                rd_val_s = mtvec_r;
            A_MEPC:                 rd_val_s = mepc_r;
            A_MIP:                  rd_val_s = mip_s;
            A_MCYCLE, A_CYCLE:      rd_val_s = cycle_r[31:0];
            A_MCYCLEH, A_CYCLEH:    rd_val_s = cycle_r[63:32];
`ifdef CSR_INSTRET_EN
            A_MINSTRET, A_INSTRET:  rd_val_s = instret_r[31:0];
            A_MINSTRETH, A_INSTRETH: rd_val_s = instret_r[63:32];
`else
            A_MINSTRET, A_INSTRET, A_MINSTRETH, A_INSTRETH: rd_val_s = 32'h0000_0000;
`endif
            default:                rd_val_s = 32'h0000_0000;
        endcase
    end

    // Read data port and fetch redirect selection.
    always_comb begin
        if (csr_en) begin
            csr_rdata = rd_val_s;
        end else begin
            csr_rdata = 32'h0000_0000;
        end
        if (trap_s) begin
            redirect    = 1'b1;
            redirect_pc = mtvec_r;
        end else if (mret_s) begin
            redirect    = 1'b1;
            redirect_pc = mepc_r;
        end else begin
            redirect    = 1'b0;
            redirect_pc = 32'h0000_0000;
        end
    end

    assign wfi_hold = wfi_hold_r;

`ifdef CSR_INSTRET_EN
    assign unused_s = ^irq_pc[1:0];
`else
    assign unused_s = ^{irq_pc[1:0], retire};
`endif

    // RUN/WAIT state machine; wfi_hold mirrors the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wfi_hold_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (wfi_go_s) begin
                        state_r    <= ST_WAIT;
                        wfi_hold_r <= 1'b1;
                    end else begin
                        state_r    <= ST_RUN;
                        wfi_hold_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (pending_s != 32'h0000_0000) begin
                        state_r    <= ST_RUN;
                        wfi_hold_r <= 1'b0;
                    end else begin
                        state_r    <= ST_WAIT;
                        wfi_hold_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    wfi_hold_r <= 1'b0;
                end
            endcase
        end
    end

    // Control/status registers: trap entry outranks mret, which outranks a CSR write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_mtie_r     <= 1'b0;
            mie_meie_r     <= 1'b0;
            mtvec_r        <= MTVEC_RST & 32'hFFFF_FFFC;
            mepc_r         <= 32'h0000_0000;
        end else begin
            if (trap_s) begin
                mstatus_mpie_r <= mstatus_mie_r;
                mstatus_mie_r  <= 1'b0;
            end else if (mret_s) begin
                mstatus_mie_r  <= mstatus_mpie_r;
                mstatus_mpie_r <= 1'b1;
            end else if (csr_we_s && (csr_addr == A_MSTATUS)) begin
                mstatus_mie_r  <= wval_s[3];
                mstatus_mpie_r <= wval_s[7];
            end else begin
                mstatus_mie_r  <= mstatus_mie_r;
                mstatus_mpie_r <= mstatus_mpie_r;
            end

            if (trap_s) begin
                mepc_r <= {irq_pc[31:2], 2'b00};
            end else if (csr_we_s && (csr_addr == A_MEPC)) begin
                mepc_r <= {wval_s[31:2], 2'b00};
            end else begin
                mepc_r <= mepc_r;
            end

            if (csr_we_s && (csr_addr == A_MIE)) begin
                mie_mtie_r <= wval_s[7];
                mie_meie_r <= wval_s[11];
            end else begin
                mie_mtie_r <= mie_mtie_r;
                mie_meie_r <= mie_meie_r;
            end

            if (csr_we_s && (csr_addr == A_MTVEC)) begin
                mtvec_r <= {wval_s[31:2], 2'b00};
            end else begin
                mtvec_r <= mtvec_r;
            end
        end
    end

    // Cycle counter; a write to either half freezes the other half for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_r <= 64'h0;
        end else if (csr_we_s && (csr_addr == A_MCYCLE)) begin
            cycle_r <= {cycle_r[63:32], wval_s};
        end else if (csr_we_s && (csr_addr == A_MCYCLEH)) begin
            cycle_r <= {wval_s, cycle_r[31:0]};
        end else begin
            cycle_r <= cycle_r + 64'd1;
        end
    end

`ifdef CSR_INSTRET_EN
    // Retired-instruction counter; no retirement is counted while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= 64'h0;
        end else if (csr_we_s && (csr_addr == A_MINSTRET)) begin
            instret_r <= {instret_r[63:32], wval_s};
        end else if (csr_we_s && (csr_addr == A_MINSTRETH)) begin
            instret_r <= {wval_s, instret_r[31:0]};
        end else if (retire && !stall && (state_r == ST_RUN)) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: inputs change on the falling edge, outputs checked in the low phase.
module tb_csr_unit;

    logic        clk;
    logic        rst;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        stall;
    logic        retire;
    logic        mret;
    logic        wfi;
    logic [31:0] irq_pc;
    logic        ext_irq;
    logic        tmr_irq;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        wfi_hold;

    int n_tests;
    int n_fail;
    logic [31:0] v;

    csr_unit #(.MTVEC_RST(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .stall(stall), .retire(retire),
        .mret(mret), .wfi(wfi), .irq_pc(irq_pc), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
        .redirect(redirect), .redirect_pc(redirect_pc), .wfi_hold(wfi_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Combinational read with op=00; call at most three times per low phase.
    task automatic rd(input logic [11:0] a, output logic [31:0] val);
        csr_en = 1'b1; csr_op = 2'b00; csr_addr = a; csr_wdata = 32'h0;
        #1;
        val = csr_rdata;
        csr_en = 1'b0;
    endtask

    // Present a CSR instruction for one cycle, returning at the next falling edge.
    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        @(negedge clk);
        csr_en = 1'b0; csr_op = 2'b00; csr_wdata = 32'h0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
        stall = 1'b0; retire = 1'b0; mret = 1'b0; wfi = 1'b0; irq_pc = 32'h0;
        ext_irq = 1'b0; tmr_irq = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_redirect", {63'h0, redirect}, 64'h0);
        chk("rst_redirect_pc", {32'h0, redirect_pc}, 64'h0);
        chk("rst_wfi_hold", {63'h0, wfi_hold}, 64'h0);
        rd(12'h305, v); chk("rst_mtvec", {32'h0, v}, 64'h0);
        rd(12'hC00, v); chk("rst_cycle", {32'h0, v}, 64'h0);
        chk("rdata_en0", {32'h0, csr_rdata}, 64'h0);

        // Ten edges after release the cycle counter reads 10; RW to the alias is ignored.
        rst = 1'b0;
        repeat (10) @(negedge clk);
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'hC00; csr_wdata = 32'h0; #1;
        chk("cycle_10", {32'h0, csr_rdata}, 64'd10);
        @(negedge clk);
        csr_en = 1'b0; csr_op = 2'b00;
        rd(12'hC00, v); chk("cycle_ro_alias", {32'h0, v}, 64'd11);
        rd(12'hC80, v); chk("cycleh_zero", {32'h0, v}, 64'h0);

        // mtvec low bits dropped, mstatus set-bits
        wr(2'b01, 12'h305, 32'h0000_1003);
        csr_en = 1'b1; csr_op = 2'b10; csr_addr = 12'h300; csr_wdata = 32'h8; #1;
        chk("rs_old_mstatus", {32'h0, csr_rdata}, 64'h0);
        @(negedge clk);
        csr_en = 1'b0; csr_op = 2'b00;
        rd(12'h305, v); chk("mtvec_1000", {32'h0, v}, 64'h1000);
        rd(12'h300, v); chk("mstatus_8", {32'h0, v}, 64'h8);

        // Stalled write is dropped
        stall = 1'b1;
        wr(2'b01, 12'h305, 32'h0000_2000);
        stall = 1'b0;
        rd(12'h305, v); chk("stall_no_write", {32'h0, v}, 64'h1000);

        // External interrupt trap entry; simultaneous mtvec write must be suppressed.
        wr(2'b01, 12'h304, 32'h0000_0800);
        irq_pc = 32'h0000_0200; ext_irq = 1'b1;
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h305; csr_wdata = 32'h0000_4000; #1;
        chk("trap_redirect", {63'h0, redirect}, 64'h1);
        chk("trap_pc", {32'h0, redirect_pc}, 64'h1000);
        @(negedge clk);
        csr_en = 1'b0; csr_op = 2'b00;
        chk("post_trap_no_redirect", {63'h0, redirect}, 64'h0);
        rd(12'h344, v); chk("mip_ext", {32'h0, v}, 64'h800);
        rd(12'h341, v); chk("mepc_200", {32'h0, v}, 64'h200);
        rd(12'h300, v); chk("mstatus_80", {32'h0, v}, 64'h80);
        ext_irq = 1'b0;
        @(negedge clk);
        rd(12'h305, v); chk("trap_write_suppressed", {32'h0, v}, 64'h1000);

        // Stalled mret does nothing; real mret restores MIE
        stall = 1'b1; mret = 1'b1; #1;
        chk("mret_stall_no_redirect", {63'h0, redirect}, 64'h0);
        @(negedge clk);
        stall = 1'b0; #1;
        chk("mret_redirect", {63'h0, redirect}, 64'h1);
        chk("mret_pc", {32'h0, redirect_pc}, 64'h200);
        @(negedge clk);
        mret = 1'b0;
        rd(12'h300, v); chk("mstatus_88", {32'h0, v}, 64'h88);

        // Low-half write, carry on the following increment, then high-half write
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, v); chk("mcycle_written", {32'h0, v}, 64'hFFFF_FFFF);
        rd(12'hB80, v); chk("mcycleh_kept", {32'h0, v}, 64'h0);
        @(negedge clk);
        rd(12'hB80, v); chk("mcycleh_carry", {32'h0, v}, 64'h1);
        rd(12'hB00, v); chk("mcycle_wrap", {32'h0, v}, 64'h0);
        wr(2'b01, 12'hB80, 32'h5);
        rd(12'hB80, v); chk("mcycleh_written", {32'h0, v}, 64'h5);
        rd(12'hB00, v); chk("mcycle_frozen", {32'h0, v}, 64'h0);

        // instret exists only in the CSR_INSTRET_EN build
        retire = 1'b1;
        repeat (3) @(negedge clk);
        retire = 1'b0;
        rd(12'hB02, v);
`ifdef CSR_INSTRET_EN
        chk("minstret", {32'h0, v}, 64'd3);
`else
        chk("minstret_absent", {32'h0, v}, 64'd0);
`endif

        // WFI with MIE=0: hold for five cycles, wake on timer without a redirect
        wr(2'b11, 12'h300, 32'h8);
        wr(2'b01, 12'h304, 32'h80);
        wfi = 1'b1;
        @(negedge clk);
        wfi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("wfi_hold_high", {63'h0, wfi_hold}, 64'h1);
            if (i == 4) tmr_irq = 1'b1;
            #1;
            chk("wfi_no_redirect", {63'h0, redirect}, 64'h0);
            @(negedge clk);
        end
        chk("wfi_woke", {63'h0, wfi_hold}, 64'h0);
        chk("wfi_woke_no_redirect", {63'h0, redirect}, 64'h0);

        // WFI with MIE=1: no trap in the wake cycle, trap the cycle after
        tmr_irq = 1'b0;
        wr(2'b10, 12'h300, 32'h8);
        wfi = 1'b1;
        @(negedge clk);
        wfi = 1'b0;
        chk("wfi2_hold", {63'h0, wfi_hold}, 64'h1);
        tmr_irq = 1'b1; irq_pc = 32'h0000_0303; #1;
        chk("wake_cycle_no_trap", {63'h0, redirect}, 64'h0);
        @(negedge clk);
        chk("after_wake_hold", {63'h0, wfi_hold}, 64'h0);
        chk("after_wake_trap", {63'h0, redirect}, 64'h1);
        chk("after_wake_pc", {32'h0, redirect_pc}, 64'h1000);
        @(negedge clk);
        tmr_irq = 1'b0;
        rd(12'h341, v); chk("mepc_aligned", {32'h0, v}, 64'h300);

        // Reset while waiting returns to RUN and restores defaults
        wfi = 1'b1;
        @(negedge clk);
        wfi = 1'b0;
        chk("wfi3_hold", {63'h0, wfi_hold}, 64'h1);
        rst = 1'b1; #1;
        chk("rst_wait_hold", {63'h0, wfi_hold}, 64'h0);
        chk("rst_wait_redirect", {63'h0, redirect}, 64'h0);
        rd(12'h305, v); chk("rst_wait_mtvec", {32'h0, v}, 64'h0);
        rd(12'hB80, v); chk("rst_wait_cycleh", {32'h0, v}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_hold", {63'h0, wfi_hold}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter: MTVEC_RST, 32'h0000_0000, mtvec reset value; bits [1:0] SHALL be treated as zero.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 csr_en  in  1  valid CSR instruction in EX this cycle.
REQ-005 csr_op  in  2  01 RW, 10 RS, 11 RC, 00 no-op.
REQ-006 csr_addr  in  12  CSR address.
REQ-007 csr_wdata  in  32  rs1 value or zero-extended zimm.
REQ-008 csr_rdata  out  32  old CSR value for rd writeback.
REQ-009 stall  in  1  pipeline stalled; suppresses CSR writes, retire, trap entry, mret.
REQ-010 retire  in  1  one instruction retired this cycle.
REQ-011 mret  in  1  MRET in EX.
REQ-012 wfi  in  1  WFI in EX.
REQ-013 irq_pc  in  32  PC of oldest unretired instruction, saved on trap entry.
REQ-014 ext_irq, tmr_irq  in  1 each  level-sensitive interrupt requests.
REQ-015 redirect  out  1  pipeline flush plus fetch redirect this cycle.
REQ-016 redirect_pc  out  32  target when redirect=1, else 0.
REQ-017 wfi_hold  out  1  stall pipeline while in WAIT state.

Function
REQ-018 CSR map SHALL be: mstatus 0x300 (bit3 MIE, bit7 MPIE, others 0); mie 0x304 (bit7 MTIE, bit11 MEIE); mtvec 0x305; mepc 0x341 (bits[1:0]=0); mip 0x344 read-only (bit7=tmr_irq, bit11=ext_irq); mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82; cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82 read-only aliases.
REQ-019 csr_rdata SHALL be combinational, old value of csr_addr; 0 for unimplemented addresses or csr_en=0.
REQ-020 Write value SHALL be: RW wdata; RS old|wdata; RC old&~wdata; committed at edge when csr_en & op!=00 & !stall & no trap entry.
REQ-021 Writes to read-only or unimplemented addresses SHALL be ignored.
REQ-022 64-bit cycle counter SHALL increment every cycle, wrapping 2^64-1 to 0; CSR write to one half SHALL replace that half, and the other half SHALL keep its old value (no carry that cycle).
REQ-023 64-bit instret counter SHALL increment when retire & !stall; same write precedence and wrap as cycle.
REQ-024 pending = mip & mie; trap entry SHALL occur in RUN when mstatus.MIE & pending!=0 & !stall.
REQ-025 On trap entry: redirect=1, redirect_pc=mtvec; at edge mepc<=irq_pc, MPIE<=MIE, MIE<=0; same-cycle CSR write and mret SHALL be suppressed.
REQ-026 mret & !stall & no trap entry: redirect=1, redirect_pc=mepc; at edge MIE<=MPIE, MPIE<=1.
REQ-027 FSM states RUN, WAIT; RUN->WAIT on wfi & !stall & no trap entry; WAIT->RUN when pending!=0, regardless of MIE; wfi_hold=1 only in WAIT.
REQ-028 In WAIT the cycle counter SHALL keep counting and instret SHALL not increment.
REQ-029 Trap entry SHALL be evaluated in the cycle after WAIT->RUN, not in the transition cycle.

Reset
REQ-030 rst SHALL force: state RUN, mstatus=0, mie=0, mepc=0, mtvec=MTVEC_RST, cycle=0, instret=0.
REQ-031 During/after reset redirect=0, redirect_pc=0, wfi_hold=0; reset mid-WAIT SHALL return to RUN.

Configuration
REQ-032 Macro CSR_INSTRET_EN: defined -> instret counter and 0xB02/0xB82/0xC02/0xC82 implemented per REQ-023.
REQ-033 Macro undefined -> no instret register; those addresses read 0, writes ignored, retire unused.

Verification
REQ-034 Reset release, 10 cycles, csr_en, RW, 0xC00 -> csr_rdata=10 (cycle 0 at first post-reset edge count).
REQ-035 RW 0x305 wdata 0x0000_1003 then RS 0x300 wdata 0x8 -> mtvec reads 0x0000_1000, mstatus reads 0x8.
REQ-036 mie=0x800, MIE=1, ext_irq=1, irq_pc=0x200 -> redirect=1, redirect_pc=0x1000; next cycle mepc=0x200, mstatus=0x80.
REQ-037 mret with mstatus=0x80 -> redirect_pc=mepc, next mstatus=0x88.
REQ-038 RW 0xB00 wdata 0xFFFF_FFFF with cycleh=0 -> next cycle 0x0000_0001_0000_0000 after one more increment.
REQ-039 wfi, MIE=0, mie=0x80, tmr_irq asserted 5 cycles later -> wfi_hold high 5 cycles, no redirect, returns to RUN.
